// File: rtl/cpu_pkg.sv
// Shared definitions for the datapath back end.
//   LS_BYTE / LS_HALF / LS_WORD : load-size codes carried with each instruction
//   XZR                         : index of the zero register (never written)
//   wb_entry_t                  : one pending write-back queue entry
//   wb_state_e                  : head-of-queue state in writeback_m
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu_result;
        logic              reg_write;
        logic              mem_to_reg;
        logic [1:0]        load_size;
        logic              load_signed;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_RETIRE    = 2'd1,
        ST_WAIT_LOAD = 2'd2
    } wb_state_e;

endpackage

// File: rtl/writeback_m_if.sv
// Bundle of the write-back stage's bus signals.
//   in_*        : retiring instruction from the memory stage (valid/ready)
//   mem_*       : load data returning from memory
//   RegWrite, writeRegister, writeData : register-file write port
//   pending, err: status
// slave  : view used by writeback_m
// master : view used by whatever drives the stage
interface writeback_m_if;
    import cpu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [REG_W-1:0]      in_rd;
    logic [DATA_W-1:0]     in_alu_result;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;
    logic [1:0]            in_load_size;
    logic                  in_load_signed;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  RegWrite;
    logic [REG_W-1:0]      writeRegister;
    logic [DATA_W-1:0]     writeData;
    logic                  pending;
    logic                  err;

    modport slave (
        input  in_valid, in_rd, in_alu_result, in_reg_write, in_mem_to_reg,
               in_load_size, in_load_signed, mem_rvalid, mem_rdata,
        output in_ready, RegWrite, writeRegister, writeData, pending, err
    );

    modport master (
        output in_valid, in_rd, in_alu_result, in_reg_write, in_mem_to_reg,
               in_load_size, in_load_signed, mem_rvalid, mem_rdata,
        input  in_ready, RegWrite, writeRegister, writeData, pending, err
    );

endinterface

// File: rtl/wb_queue_m.sv
// Generic synchronous FIFO.
//   clk, reset   : clock, synchronous active-high reset (clears pointers/count)
//   push/push_data : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   head_data    : entry at the read pointer
//   second_data  : entry behind the head (meaningful only when count >= 2)
//   count, full, empty : occupancy
module wb_queue_m #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [WIDTH-1:0] second_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_data   = mem[rd_ptr];
    assign second_data = mem[rd_ptr + AW'(1)];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/writeback_m.sv
// Write-back stage: queues retiring instructions in order, waits for load
// data when the head is a load, and drives the register-file write port.
//   clk, reset : clock, synchronous active-high reset
//   bus        : writeback_m_if.slave (instruction in, load data in,
//                RegWrite/writeRegister/writeData out, pending, err)
// Parameters: DEPTH (queue entries, power of two >= 2), XZR (zero register).
module writeback_m
    import cpu_pkg::*;
#(
    parameter int               DEPTH = 2,
    parameter logic [REG_W-1:0] XZR   = cpu_pkg::XZR
) (
    input  logic          clk,
    input  logic          reset,
    writeback_m_if.slave  bus
);

    localparam int ENTRY_W = $bits(wb_entry_t);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        size,
        input logic              is_signed
    );
        logic [DATA_W-1:0] r;
        case (size)
            LS_BYTE: r = {{(DATA_W-8){is_signed & d[7]}}, d[7:0]};
            LS_HALF: r = {{(DATA_W-16){is_signed & d[15]}}, d[15:0]};
            default: r = d;  // word and the reserved code
        endcase
        return r;
    endfunction

    // State a given entry puts the FSM in once it becomes head.
    function automatic wb_state_e entry_state(input wb_entry_t e);
        return e.mem_to_reg ? ST_WAIT_LOAD : ST_RETIRE;
    endfunction

    wb_entry_t          in_entry;
    wb_entry_t          head;
    wb_entry_t          second;
    logic [ENTRY_W-1:0] head_bits;
    logic [ENTRY_W-1:0] second_bits;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               retire;
    logic [DATA_W-1:0]  result_p0;
    wb_state_e          state_q;
    wb_state_e          state_d;

    logic               vld_p1;
    logic [REG_W-1:0]   wreg_p1;
    logic [DATA_W-1:0]  wdata_p1;
    logic               err_q;

    assign in_entry = '{
        rd:          bus.in_rd,
        alu_result:  bus.in_alu_result,
        reg_write:   bus.in_reg_write,
        mem_to_reg:  bus.in_mem_to_reg,
        load_size:   bus.in_load_size,
        load_signed: bus.in_load_signed
    };

    // Ready is pure registered state, held low during reset.
    assign bus.in_ready = !full && !reset;
    assign push         = bus.in_valid && bus.in_ready;

    wb_queue_m #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_data   (in_entry),
        .pop         (retire),
        .head_data   (head_bits),
        .second_data (second_bits),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    assign head   = wb_entry_t'(head_bits);
    assign second = wb_entry_t'(second_bits);

    // Stage p0: head selection and result formation
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;

        case (state_q)
            ST_RETIRE:    retire = 1'b1;
            ST_WAIT_LOAD: retire = bus.mem_rvalid;
            default:      retire = 1'b0;
        endcase

        // The next head is the entry behind the current one, or, when the
        // queue drains to empty this cycle, whatever is being pushed now.
        if (retire) begin
            if (count == CNT_W'(1)) begin
                state_d = push ? entry_state(in_entry) : ST_EMPTY;
            end else begin
                state_d = entry_state(second);
            end
        end else if (state_q == ST_EMPTY && push) begin
            state_d = entry_state(in_entry);
        end
    end

    assign result_p0 = head.mem_to_reg
                     ? extend_load(bus.mem_rdata, head.load_size, head.load_signed)
                     : head.alu_result;

    // Stage p1: registered register-file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            vld_p1   <= 1'b0;
            wreg_p1  <= '0;
            wdata_p1 <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= retire && head.reg_write && (head.rd != XZR);
            if (retire) begin
                wreg_p1  <= head.rd;
                wdata_p1 <= result_p0;
            end
            // Load data with no load waiting at the head is dropped.
            if (bus.mem_rvalid && state_q != ST_WAIT_LOAD) err_q <= 1'b1;
        end
    end

    assign bus.RegWrite      = vld_p1;
    assign bus.writeRegister = wreg_p1;
    assign bus.writeData     = wdata_p1;
    assign bus.pending       = !empty;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_writeback_m.sv
module tb_writeback_m;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_m_if bus ();

    writeback_m #(.DEPTH(DEPTH), .XZR(5'd31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        rw;
        logic        ld;
        logic [1:0]  sz;
        logic        sgn;
    } instr_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    instr_t      mq[$];     // instructions accepted and not yet retired
    wr_t         expq[$];   // register writes expected, with their cycle
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    logic        exp_err = 1'b0;
    logic [4:0]  last_rd = '0;
    logic [31:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load extension from the arithmetic definition: keep the low bits,
    // reinterpret as two's complement when signed.
    function automatic logic [31:0] ext_model(input logic [31:0] d, input logic [1:0] sz, input logic sgn);
        longint bits;
        longint v;
        bits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        v = longint'(d) & ((64'sd1 <<< bits) - 1);
        if (sgn && bits < 32 && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
        return v[31:0];
    endfunction

    // Reference model: updated at each active edge from the inputs held there.
    always @(posedge clk) begin : model
        instr_t      h;
        logic [31:0] res;
        logic        head_ld;
        logic        acc;
        cyc++;
        if (reset) begin
            mq.delete();
            expq.delete();
            exp_err = 1'b0;
        end else begin
            head_ld = (mq.size() > 0) && mq[0].ld;
            acc     = bus.in_valid && (mq.size() < DEPTH);
            if (bus.mem_rvalid && !head_ld) exp_err = 1'b1;
            if (mq.size() > 0 && (!mq[0].ld || bus.mem_rvalid)) begin
                h   = mq.pop_front();
                res = h.ld ? ext_model(bus.mem_rdata, h.sz, h.sgn) : h.alu;
                if (h.rw && h.rd != 5'd31) expq.push_back('{rd: h.rd, data: res, cyc: cyc});
            end
            if (acc) mq.push_back('{rd: bus.in_rd, alu: bus.in_alu_result, rw: bus.in_reg_write,
                                    ld: bus.in_mem_to_reg, sz: bus.in_load_size, sgn: bus.in_load_signed});
        end
    end

    // Monitor: samples on the falling edge and compares with the scoreboard.
    always @(negedge clk) begin : monitor
        wr_t w;
        if (cyc > 0) begin
            check("in_ready", 32'(bus.in_ready), 32'(!reset && (mq.size() < DEPTH)));
            check("pending", 32'(bus.pending), 32'(mq.size() > 0));
            check("err", 32'(bus.err), 32'(exp_err));
            if (bus.RegWrite) begin
                n_writes++;
                last_rd   = bus.writeRegister;
                last_data = bus.writeData;
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write (cycle %0d)",
                             bus.writeRegister, bus.writeData, cyc);
                end else begin
                    w = expq.pop_front();
                    check("write_rd", 32'(bus.writeRegister), 32'(w.rd));
                    check("write_data", bus.writeData, w.data);
                    check("write_cycle", 32'(cyc), 32'(w.cyc));
                end
            end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                w = expq.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_write: got no write, expected rd=%0d data=%h (cycle %0d)",
                         w.rd, w.data, cyc);
            end
        end
    end

    task automatic set_in(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                          input logic rw, input logic ld, input logic [1:0] sz, input logic sgn,
                          input logic rv, input logic [31:0] rdata);
        bus.in_valid       = v;
        bus.in_rd          = rd;
        bus.in_alu_result  = alu;
        bus.in_reg_write   = rw;
        bus.in_mem_to_reg  = ld;
        bus.in_load_size   = sz;
        bus.in_load_signed = sgn;
        bus.mem_rvalid     = rv;
        bus.mem_rdata      = rdata;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                         input logic rw, input logic ld, input logic [1:0] sz, input logic sgn,
                         input logic rv, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        set_in(v, rd, alu, rw, ld, sz, sgn, rv, rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 0, 32'd0);
    endtask

    task automatic pulse_reset(input int n, input logic rv);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_in(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, rv, 32'hDEAD_BEEF);
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 0, 32'd0);
    endtask

    initial begin
        int  w0;
        logic head_ld;
        reset = 1'b1;
        set_in(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 0, 32'd0);
        pulse_reset(3, 1'b0);

        @(negedge clk);
        check("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
        check("rst_writeRegister", 32'(bus.writeRegister), 32'd0);
        check("rst_writeData", bus.writeData, 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single non-load write.
        w0 = n_writes;
        drive(1, 5'd5, 32'h0000_00AA, 1, 0, LS_WORD, 0, 0, 32'd0);
        idle(4);
        check("alu_write_count", 32'(n_writes - w0), 32'd1);
        check("alu_write_rd", 32'(last_rd), 32'd5);
        check("alu_write_data", last_data, 32'h0000_00AA);
        check("alu_pending_clear", 32'(bus.pending), 32'd0);

        // Signed byte load, data arriving several cycles later.
        drive(1, 5'd3, 32'h1111_1111, 1, 1, LS_BYTE, 1, 0, 32'd0);
        idle(3);
        drive(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 1, 32'h0000_0080);
        idle(2);
        check("sbyte_rd", 32'(last_rd), 32'd3);
        check("sbyte_data", last_data, 32'hFFFF_FF80);

        // Unsigned half load.
        drive(1, 5'd7, 32'h2222_2222, 1, 1, LS_HALF, 0, 0, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 1, 32'hFFFF_8001);
        idle(2);
        check("uhalf_rd", 32'(last_rd), 32'd7);
        check("uhalf_data", last_data, 32'h0000_8001);

        // Write to the zero register is suppressed.
        w0 = n_writes;
        drive(1, 5'd31, 32'h1234_5678, 1, 0, LS_WORD, 0, 0, 32'd0);
        idle(4);
        check("xzr_no_write", 32'(n_writes - w0), 32'd0);
        check("xzr_pending_clear", 32'(bus.pending), 32'd0);

        // Load stalls at head while non-loads fill the queue.
        w0 = n_writes;
        drive(1, 5'd1, 32'd0, 1, 1, LS_WORD, 0, 0, 32'd0);
        drive(1, 5'd2, 32'h0000_0022, 1, 0, LS_WORD, 0, 0, 32'd0);
        drive(1, 5'd3, 32'h0000_0033, 1, 0, LS_WORD, 0, 0, 32'd0);
        @(negedge clk);
        check("full_in_ready_low", 32'(bus.in_ready), 32'd0);
        drive(1, 5'd3, 32'h0000_0033, 1, 0, LS_WORD, 0, 1, 32'h0000_0011);
        drive(1, 5'd3, 32'h0000_0033, 1, 0, LS_WORD, 0, 0, 32'd0);
        idle(4);
        check("fill_write_count", 32'(n_writes - w0), 32'd3);
        check("fill_last_rd", 32'(last_rd), 32'd3);
        check("fill_in_ready_back", 32'(bus.in_ready), 32'd1);

        // Stray load data while empty sets the sticky error.
        w0 = n_writes;
        idle(2);
        drive(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 1, 32'h5555_5555);
        idle(1);
        check("stray_err_set", 32'(bus.err), 32'd1);
        idle(3);
        check("stray_err_sticky", 32'(bus.err), 32'd1);
        check("stray_no_write", 32'(n_writes - w0), 32'd0);

        // Reset clears err; load data during reset is ignored.
        pulse_reset(1, 1'b1);
        @(negedge clk);
        check("reset_clears_err", 32'(bus.err), 32'd0);

        // Reset in WAIT_LOAD with two entries queued.
        drive(1, 5'd4, 32'd0, 1, 1, LS_WORD, 0, 0, 32'd0);
        drive(1, 5'd6, 32'h0000_0066, 1, 0, LS_WORD, 0, 0, 32'd0);
        pulse_reset(1, 1'b0);
        @(negedge clk);
        check("midreset_pending", 32'(bus.pending), 32'd0);
        check("midreset_RegWrite", 32'(bus.RegWrite), 32'd0);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        idle(1);
        drive(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 1, 32'h7777_7777);
        idle(1);
        check("late_rvalid_err", 32'(bus.err), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                set_in(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 1'($urandom), 32'd0);
            end else begin
                reset   = 1'b0;
                head_ld = (mq.size() > 0) && mq[0].ld;
                set_in(1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom),
                       head_ld ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0),
                       $urandom);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(0, 5'd0, 32'd0, 0, 0, 2'b00, 0, 0, 32'd0);
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_m.md
# writeback_m

Write-back stage of the single-issue datapath: accepts retiring instructions from the memory stage, holds them in order in a small queue, waits for load data where needed, and produces the one-write-per-cycle port (`RegWrite`, `writeRegister`, `writeData`) that feeds the register file. It is the writer end of the register-file interface. It also enforces the XZR rule: register 31 is never written.

## Interface
Parameters:
- `DEPTH`, 2: pending-instruction queue entries; power of two, at least 2.
- `XZR`, 31: index of the zero register; writes to it are suppressed.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  memory stage presents a retiring instruction.
- `in_ready`  out  1  queue can accept; transfer occurs when `in_valid && in_ready` at the edge.
- `in_rd`  in  5  destination register.
- `in_alu_result`  in  32  ALU result, used when not a load.
- `in_reg_write`  in  1  instruction writes `in_rd`.
- `in_mem_to_reg`  in  1  instruction is a load; result comes from `mem_rdata`.
- `in_load_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `in_load_signed`  in  1  sign-extend (1) or zero-extend (0) sub-word loads.
- `mem_rvalid`  in  1  load data is valid this cycle.
- `mem_rdata`  in  32  load data, right-aligned.
- `RegWrite`  out  1  register-file write strobe; one-cycle pulse per write.
- `writeRegister`  out  5  write index.
- `writeData`  out  32  write value.
- `pending`  out  1  queue non-empty.
- `err`  out  1  sticky: `mem_rvalid` arrived with no load at the queue head.

## Operation
- In-order queue of `DEPTH` entries, each holding {rd, alu_result, reg_write, mem_to_reg, load_size, load_signed}.
- `in_ready = !full`. It is registered-state only and does not depend on `mem_rvalid`.
- Head FSM:
  - EMPTY: queue empty. Go to RETIRE or WAIT_LOAD when an entry becomes head.
  - RETIRE: head is a non-load. Retire it this cycle. The next state is decided by the new head.
  - WAIT_LOAD: head is a load. Stay until `mem_rvalid`, then retire the head that cycle using the extended `mem_rdata`.
- Retiring an entry:
  - Dequeue it.
  - On the next edge, register `RegWrite = reg_write && (rd != XZR)`, `writeRegister = rd`, `writeData = result`.
  - When `RegWrite` is 0, `writeRegister` and `writeData` still update; downstream logic must ignore them.
- Extension:
  - byte: `mem_rdata[7:0]`, extended to 32 bits.
  - half: `mem_rdata[15:0]`, extended to 32 bits.
  - word: passed through unchanged.
- A load with `reg_write = 0` still waits for and consumes its `mem_rvalid`.
- `mem_rvalid` in EMPTY or RETIRE: the data is dropped, `err` is set, and the queue is unaffected.
- Enqueue and dequeue in the same cycle are allowed. Count is unchanged; pointers wrap modulo `DEPTH`.
- Enqueue into an empty queue: the entry becomes head on the next cycle. There is no same-cycle bypass.

## Timing
- Reset values: `RegWrite` 0, `writeRegister` 0, `writeData` 0, `pending` 0, `err` 0, queue empty, FSM EMPTY.
- `in_ready` is 0 while `reset` is high and 1 on the first cycle after.
- Non-load latency: accepted at edge N, head during cycle N+1, `RegWrite` high during cycle N+2.
- Load latency: `RegWrite` is high the cycle after the `mem_rvalid` cycle. The minimum is edge N accept, `mem_rvalid` in cycle N+1, write in cycle N+2.
- Throughput: one retire per cycle for back-to-back non-loads.
- Full queue: `in_ready` drops the cycle after the count reaches `DEPTH`. It rises the cycle after a dequeue that is not paired with an enqueue.
- Reset mid-operation:
  - Pending entries are discarded.
  - An in-flight load's `mem_rvalid` arriving after reset sets `err`; upstream must also be reset.
  - `mem_rvalid` is ignored while `reset` is high.
- `RegWrite` is never high for two cycles on behalf of one entry.

## Structure
- `cpu_pkg` holds:
  - load-size codes `LS_BYTE`, `LS_HALF`, `LS_WORD`;
  - the `XZR` constant;
  - the queue entry struct `wb_entry_t`.
- Sub-module `wb_queue_m`: parameterised synchronous FIFO with `full`, `empty`, head view and pop. It contains no protocol knowledge.
- The FSM, extension and output registers live in `writeback_m`.

## Test plan
- Reset, then `in_valid` with rd=5, alu=32'h0000_00AA, reg_write=1, non-load at edge 1 → `RegWrite`=1, `writeRegister`=5, `writeData`=32'hAA in cycle 3 only; `pending` back to 0 after.
- Signed byte load, rd=3, then `mem_rdata`=32'h0000_0080 with `mem_rvalid` 4 cycles later → `writeData`=32'hFFFF_FF80 the next cycle. Unsigned half with 32'h0000_8001 → 32'h0000_8001.
- Instruction with rd=31, reg_write=1 → entry retires, `RegWrite` stays 0, `pending` clears.
- Load at head stalled while two non-loads arrive → `in_ready`=0 once full. After `mem_rvalid`, writes occur in issue order on three consecutive cycles; `in_ready` returns to 1.
- `mem_rvalid` pulse while queue is empty → `err`=1 and stays 1 until reset; no `RegWrite`.
- Reset asserted in WAIT_LOAD with 2 entries queued → next cycle `pending`=0, `RegWrite`=0, `in_ready`=1. A later stray `mem_rvalid` sets `err`.
